// File: rtl/banco_registradores_param_if.sv
// Decode/writeback bus of the parametrised register bank.
// Decode drives read addresses and reservations; writeback drives the write port.
interface banco_registradores_param_if #(
  parameter int LARGURA  = 8,
  parameter int NUM_REGS = 4
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic               escrita;
  logic [ADDR_W-1:0]  regEscrita;
  logic [LARGURA-1:0] valorEscrita;
  logic [ADDR_W-1:0]  regLeituraA;
  logic [ADDR_W-1:0]  regLeituraB;
  logic [LARGURA-1:0] valorSaidaA;
  logic [LARGURA-1:0] valorSaidaB;
  logic               reserva;
  logic [ADDR_W-1:0]  regReserva;
  logic               pendenteA;
  logic               pendenteB;

  modport master (
    output escrita, regEscrita, valorEscrita,
    output regLeituraA, regLeituraB,
    output reserva, regReserva,
    input  valorSaidaA, valorSaidaB,
    input  pendenteA, pendenteB
  );

  modport slave (
    input  escrita, regEscrita, valorEscrita,
    input  regLeituraA, regLeituraB,
    input  reserva, regReserva,
    output valorSaidaA, valorSaidaB,
    output pendenteA, pendenteB
  );
endinterface

// File: rtl/banco_registradores_param.sv
// Register bank, 2 registered read ports with write bypass, pending scoreboard.
// Optional REG_ZERO_HARDWIRED_EN makes register 0 a constant zero.
module banco_registradores_param #(
  parameter int LARGURA  = 8,
  parameter int NUM_REGS = 4
) (
  input logic clock,
  input logic reset,
  banco_registradores_param_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic [LARGURA-1:0]  regs_q [NUM_REGS];
  logic [LARGURA-1:0]  regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [LARGURA-1:0]  va_q, va_d;
  logic [LARGURA-1:0]  vb_q, vb_d;
  logic                pa_q, pa_d;
  logic                pb_q, pb_d;

  logic wr_en, rsv_en;
  logic zero_a, zero_b;

  always_comb begin
    wr_en  = bus.escrita;
    rsv_en = bus.reserva;
    zero_a = 1'b0;
    zero_b = 1'b0;
    if (ZERO_EN) begin
      wr_en  = bus.escrita && (bus.regEscrita != '0);
      rsv_en = bus.reserva && (bus.regReserva != '0);
      zero_a = (bus.regLeituraA == '0);
      zero_b = (bus.regLeituraB == '0);
    end
  end

  // Clear before set: a fresh reservation outranks the retiring write.
  always_comb begin
    pend_d = pend_q;
    if (wr_en)
      pend_d[bus.regEscrita] = 1'b0;
    if (rsv_en)
      pend_d[bus.regReserva] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      regs_d[i] = regs_q[i];
    if (wr_en)
      regs_d[bus.regEscrita] = bus.valorEscrita;
  end

  always_comb begin
    va_d = regs_q[bus.regLeituraA];
    vb_d = regs_q[bus.regLeituraB];
    if (wr_en && bus.regEscrita == bus.regLeituraA)
      va_d = bus.valorEscrita;
    if (wr_en && bus.regEscrita == bus.regLeituraB)
      vb_d = bus.valorEscrita;
    if (zero_a)
      va_d = '0;
    if (zero_b)
      vb_d = '0;
    pa_d = pend_d[bus.regLeituraA] & ~zero_a;
    pb_d = pend_d[bus.regLeituraB] & ~zero_b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      pend_q <= '0;
      va_q   <= '0;
      vb_q   <= '0;
      pa_q   <= 1'b0;
      pb_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= regs_d[i];
      pend_q <= pend_d;
      va_q   <= va_d;
      vb_q   <= vb_d;
      pa_q   <= pa_d;
      pb_q   <= pb_d;
    end
  end

  assign bus.valorSaidaA = va_q;
  assign bus.valorSaidaB = vb_q;
  assign bus.pendenteA   = pa_q;
  assign bus.pendenteB   = pb_q;
endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed bench: 4x8 bank plus a 8x16 bank sharing clock and reset.
// Expected values are hand-computed constants; r0 checks follow REG_ZERO_HARDWIRED_EN.
module tb_banco_registradores_param;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  banco_registradores_param_if #(.LARGURA(8), .NUM_REGS(4)) b8();
  banco_registradores_param_if #(.LARGURA(16), .NUM_REGS(8)) b16();

  banco_registradores_param #(.LARGURA(8), .NUM_REGS(4)) dut8 (
    .clock(clock),
    .reset(reset),
    .bus(b8.slave)
  );

  banco_registradores_param #(.LARGURA(16), .NUM_REGS(8)) dut16 (
    .clock(clock),
    .reset(reset),
    .bus(b16.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit ZH = 1'b1;
`else
  localparam bit ZH = 1'b0;
`endif

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle8();
    b8.escrita = 0; b8.regEscrita = 0; b8.valorEscrita = 0;
    b8.reserva = 0; b8.regReserva = 0;
  endtask

  task automatic wr8(input logic [1:0] a, input logic [7:0] v);
    b8.escrita = 1; b8.regEscrita = a; b8.valorEscrita = v;
  endtask

  initial begin
    logic [7:0] r0exp;
    checks = 0;
    failures = 0;
    reset = 1;
    idle8();
    b8.regLeituraA = 0; b8.regLeituraB = 0;
    b16.escrita = 0; b16.regEscrita = 0; b16.valorEscrita = 0;
    b16.reserva = 0; b16.regReserva = 0;
    b16.regLeituraA = 0; b16.regLeituraB = 0;
    step();
    step();
    reset = 0;

    // 1: every address reads zero, not pending
    for (int a = 0; a < 4; a++) begin
      b8.regLeituraA = 2'(a); b8.regLeituraB = 2'(3 - a);
      step();
      chk("t1_valA", 32'(b8.valorSaidaA), 0);
      chk("t1_valB", 32'(b8.valorSaidaB), 0);
      chk("t1_penA", 32'(b8.pendenteA), 0);
      chk("t1_penB", 32'(b8.pendenteB), 0);
    end

    // 2: write then read next cycle
    wr8(2, 8'hA5); b8.regLeituraA = 0;
    step();
    chk("t2_no_bypass", 32'(b8.valorSaidaA), 0);
    idle8(); b8.regLeituraA = 2;
    step();
    chk("t2_valA", 32'(b8.valorSaidaA), 32'hA5);

    // 3: same-cycle bypass on both ports
    wr8(1, 8'h3C); b8.regLeituraA = 1; b8.regLeituraB = 1;
    step();
    chk("t3_valA", 32'(b8.valorSaidaA), 32'h3C);
    chk("t3_valB", 32'(b8.valorSaidaB), 32'h3C);
    idle8(); b8.regLeituraA = 2; b8.regLeituraB = 1;
    step();
    chk("t3_holdA", 32'(b8.valorSaidaA), 32'hA5);
    chk("t3_holdB", 32'(b8.valorSaidaB), 32'h3C);

    // 4: scoreboard on r3
    b8.reserva = 1; b8.regReserva = 3; b8.regLeituraB = 3;
    step();
    chk("t4_rsv_penB", 32'(b8.pendenteB), 1);
    b8.regReserva = 3;
    step();
    chk("t4_rerSV_penB", 32'(b8.pendenteB), 1);
    idle8(); wr8(3, 8'h7E);
    step();
    chk("t4_wr_penB", 32'(b8.pendenteB), 0);
    chk("t4_wr_valB", 32'(b8.valorSaidaB), 32'h7E);
    wr8(3, 8'h11); b8.reserva = 1; b8.regReserva = 3;
    step();
    chk("t4_both_penB", 32'(b8.pendenteB), 1);
    chk("t4_both_valB", 32'(b8.valorSaidaB), 32'h11);
    idle8(); b8.regLeituraA = 2;
    step();
    chk("t4_hold_penB", 32'(b8.pendenteB), 1);
    chk("t4_other_penA", 32'(b8.pendenteA), 0);

    // 5: load, reserve, then reset with a write in flight
    for (int a = 0; a < 4; a++) begin
      wr8(2'(a), 8'(a + 1));
      step();
    end
    idle8(); b8.reserva = 1; b8.regReserva = 2;
    b8.regLeituraA = 2; b8.regLeituraB = 3;
    step();
    chk("t5_valA", 32'(b8.valorSaidaA), 3);
    chk("t5_penA", 32'(b8.pendenteA), 1);
    chk("t5_valB", 32'(b8.valorSaidaB), 4);
    chk("t5_penB", 32'(b8.pendenteB), 0);
    idle8(); wr8(1, 8'hFF); b8.regLeituraA = 1;
    reset = 1;
    step();
    chk("t5_rst_valA", 32'(b8.valorSaidaA), 0);
    chk("t5_rst_penA", 32'(b8.pendenteA), 0);
    chk("t5_rst_valB", 32'(b8.valorSaidaB), 0);
    chk("t5_rst_penB", 32'(b8.pendenteB), 0);
    reset = 0; idle8();
    for (int a = 0; a < 4; a++) begin
      b8.regLeituraA = 2'(a); b8.regLeituraB = 2'(a);
      step();
      chk("t5_post_valA", 32'(b8.valorSaidaA), 0);
      chk("t5_post_penB", 32'(b8.pendenteB), 0);
    end

    // 6: register 0 behaviour
    r0exp = ZH ? 8'h00 : 8'hFF;
    wr8(0, 8'hFF); b8.regLeituraA = 0; b8.regLeituraB = 1;
    step();
    chk("t6_bypass_r0", 32'(b8.valorSaidaA), 32'(r0exp));
    idle8();
    step();
    chk("t6_read_r0", 32'(b8.valorSaidaA), 32'(r0exp));
    b8.reserva = 1; b8.regReserva = 0;
    step();
    chk("t6_rsv_r0", 32'(b8.pendenteA), ZH ? 0 : 1);
    idle8();
    step();
    chk("t6_rsv_r0_hold", 32'(b8.pendenteA), ZH ? 0 : 1);

    // wide bank: tests 2 and 3 with r7
    b16.escrita = 1; b16.regEscrita = 7; b16.valorEscrita = 16'hBEEF;
    b16.regLeituraA = 0;
    step();
    chk("w2_no_bypass", 32'(b16.valorSaidaA), 0);
    b16.escrita = 0; b16.regLeituraA = 7;
    step();
    chk("w2_valA", 32'(b16.valorSaidaA), 32'hBEEF);
    b16.escrita = 1; b16.regEscrita = 5; b16.valorEscrita = 16'h1234;
    b16.regLeituraA = 5; b16.regLeituraB = 5;
    step();
    chk("w3_valA", 32'(b16.valorSaidaA), 32'h1234);
    chk("w3_valB", 32'(b16.valorSaidaB), 32'h1234);
    b16.escrita = 0; b16.regLeituraB = 7;
    b16.reserva = 1; b16.regReserva = 6; b16.regLeituraA = 6;
    step();
    chk("w_holdB", 32'(b16.valorSaidaB), 32'hBEEF);
    chk("w_penA", 32'(b16.pendenteA), 1);
    b16.reserva = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
